// File: rtl/gb_bus_pkg.sv
// Shared definitions for the global-bus arbiter: arbitration modes and the
// layout of each requester's valid/destination index field.
package gb_bus_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int IDX_VALID_BIT = 0;
  localparam int IDX_DEST_LSB  = 1;

  function automatic int gb_idx_len(input int log_num_pu);
    return log_num_pu + 1;
  endfunction

endpackage

// File: rtl/gb_bus_if.sv
// Bundle of per-PU request lanes and the shared registered bus outputs.
// The arbiter takes the slave side; the requesters take the master side.
interface gb_bus_if
  import gb_bus_pkg::*;
#(
  parameter int logNumPu = 3,
  parameter int dataLen  = 16
);
  localparam int numPu  = 1 << logNumPu;
  localparam int idxLen = gb_idx_len(logNumPu);

  logic [dataLen*numPu-1:0] req_data;
  logic [idxLen*numPu-1:0]  req_idx;
  logic [numPu-1:0]         req_lock;
  logic [numPu-1:0]         req_ready;
  logic [dataLen-1:0]       bus_data_out;
  logic [numPu-1:0]         bus_data_out_v;
  logic [logNumPu-1:0]      grant_id;
  logic                     bus_locked;

  modport slave (
    input  req_data, req_idx, req_lock,
    output req_ready, bus_data_out, bus_data_out_v, grant_id, bus_locked
  );

  modport master (
    output req_data, req_idx, req_lock,
    input  req_ready, bus_data_out, bus_data_out_v, grant_id, bus_locked
  );
endinterface

// File: rtl/gb_arb_picker.sv
// Combinational rotate-and-priority-encode: first set request found scanning
// from the start index upward, modulo the PU count.
module gb_arb_picker
  import gb_bus_pkg::*;
#(
  parameter int        logNumPu = 3,
  parameter arb_mode_e arbMode  = ARB_RR
) (
  input  logic [(1<<logNumPu)-1:0] req,
  input  logic [logNumPu-1:0]      start_idx,
  output logic [(1<<logNumPu)-1:0] grant,
  output logic [logNumPu-1:0]      grant_idx,
  output logic                     grant_any
);
  localparam int numPu = 1 << logNumPu;

  logic [logNumPu-1:0] base;
  logic [logNumPu-1:0] cand;

  assign base = (arbMode == ARB_FIXED) ? '0 : start_idx;

  // Scan from the far end back to the start so the nearest request wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = numPu - 1; i >= 0; i--) begin
      cand = base + logNumPu'(i);
      if (req[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/gb_bus_arbiter.sv
// Registered global-bus arbiter: one grant per cycle with optional packet
// locking, winning word and one-hot destination strobe registered onto the bus.
module gb_bus_arbiter
  import gb_bus_pkg::*;
#(
  parameter int        logNumPu = 3,
  parameter int        dataLen  = 16,
  parameter arb_mode_e arbMode  = ARB_RR
) (
  input logic     clk,
  input logic     reset,
  gb_bus_if.slave bus
);
  localparam int numPu  = 1 << logNumPu;
  localparam int idxLen = gb_idx_len(logNumPu);

  logic [numPu-1:0]    req_valid;
  logic [numPu-1:0]    pick_grant;
  logic [logNumPu-1:0] pick_idx;
  logic                pick_any;

  logic [numPu-1:0]    xfer_grant;
  logic [logNumPu-1:0] xfer_idx;
  logic                xfer;
  logic [logNumPu-1:0] dest;

  logic [logNumPu-1:0] ptr_q, ptr_d;
  logic                lock_v_q, lock_v_d;
  logic [logNumPu-1:0] lock_id_q, lock_id_d;
  logic [dataLen-1:0]  bus_data_q, bus_data_d;
  logic [numPu-1:0]    bus_v_q, bus_v_d;
  logic [logNumPu-1:0] grant_id_q, grant_id_d;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < numPu; i++) begin
      req_valid[i] = bus.req_idx[i*idxLen + IDX_VALID_BIT];
    end
  end

  gb_arb_picker #(
    .logNumPu (logNumPu),
    .arbMode  (arbMode)
  ) u_picker (
    .req       (req_valid),
    .start_idx (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  // A held lock overrides arbitration only while its owner is still valid.
  always_comb begin
    xfer_grant = pick_grant;
    xfer_idx   = pick_idx;
    xfer       = pick_any;
    if (lock_v_q && req_valid[lock_id_q]) begin
      xfer_grant            = '0;
      xfer_grant[lock_id_q] = 1'b1;
      xfer_idx              = lock_id_q;
      xfer                  = 1'b1;
    end
  end

  assign bus.req_ready = xfer_grant;

  always_comb begin
    dest       = bus.req_idx[xfer_idx*idxLen + IDX_DEST_LSB +: logNumPu];
    ptr_d      = ptr_q;
    lock_v_d   = 1'b0;
    lock_id_d  = lock_id_q;
    bus_data_d = bus_data_q;
    bus_v_d    = '0;
    grant_id_d = grant_id_q;
    if (xfer) begin
      bus_data_d    = bus.req_data[xfer_idx*dataLen +: dataLen];
      bus_v_d[dest] = 1'b1;
      grant_id_d    = xfer_idx;
      ptr_d         = xfer_idx + logNumPu'(1);
      lock_v_d      = bus.req_lock[xfer_idx];
      lock_id_d     = xfer_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      lock_v_q   <= 1'b0;
      lock_id_q  <= '0;
      bus_data_q <= '0;
      bus_v_q    <= '0;
      grant_id_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_v_q   <= lock_v_d;
      lock_id_q  <= lock_id_d;
      bus_data_q <= bus_data_d;
      bus_v_q    <= bus_v_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.bus_data_out   = bus_data_q;
  assign bus.bus_data_out_v = bus_v_q;
  assign bus.grant_id       = grant_id_q;
  assign bus.bus_locked     = lock_v_q;

endmodule

// File: tb/tb_gb_bus_arbiter.sv
// Bench for gb_bus_arbiter: fixed-priority and round-robin instances share
// stimulus and are compared against a rule-level model of the arbiter.
module tb_gb_bus_arbiter;
  import gb_bus_pkg::*;

  localparam int LOG = 3;
  localparam int NPU = 8;
  localparam int DW  = 16;
  localparam int IL  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gb_bus_if #(.logNumPu(LOG), .dataLen(DW)) rr_if ();
  gb_bus_if #(.logNumPu(LOG), .dataLen(DW)) fx_if ();

  gb_bus_arbiter #(.logNumPu(LOG), .dataLen(DW), .arbMode(ARB_RR)) u_rr (
    .clk(clk), .reset(reset), .bus(rr_if.slave));
  gb_bus_arbiter #(.logNumPu(LOG), .dataLen(DW), .arbMode(ARB_FIXED)) u_fx (
    .clk(clk), .reset(reset), .bus(fx_if.slave));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  s_data  [NPU];
  logic           s_valid [NPU];
  logic [LOG-1:0] s_dest  [NPU];
  logic           s_lock  [NPU];

  // Model state, index 0 = fixed priority instance, 1 = round-robin instance.
  int             m_ptr     [2];
  logic           m_lock_v  [2];
  int             m_lock_id [2];
  int             m_gid     [2];
  logic [DW-1:0]  m_data    [2];
  logic [NPU-1:0] m_v       [2];
  int             last_g    [2];

  function automatic int model_pick(int m);
    if (m_lock_v[m] && s_valid[m_lock_id[m]]) return m_lock_id[m];
    for (int j = 0; j < NPU; j++) begin
      int k;
      k = (m == 1) ? (m_ptr[m] + j) % NPU : j;
      if (s_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NPU-1:0] model_ready(int m);
    logic [NPU-1:0] r;
    int g;
    r = '0;
    g = model_pick(m);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [27:0] model_out(int m);
    logic [LOG-1:0] gid;
    gid = LOG'(m_gid[m]);
    return {m_data[m], m_v[m], gid, m_lock_v[m]};
  endfunction

  function automatic logic [27:0] dut_out(int m);
    if (m == 1)
      return {rr_if.bus_data_out, rr_if.bus_data_out_v, rr_if.grant_id, rr_if.bus_locked};
    return {fx_if.bus_data_out, fx_if.bus_data_out_v, fx_if.grant_id, fx_if.bus_locked};
  endfunction

  function automatic logic [NPU-1:0] dut_ready(int m);
    return (m == 1) ? rr_if.req_ready : fx_if.req_ready;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_lock_v[m] = 1'b0; m_lock_id[m] = 0;
      m_gid[m] = 0; m_data[m] = '0; m_v[m] = '0; last_g[m] = -1;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int g;
      g = model_pick(m);
      last_g[m] = g;
      if (g >= 0) begin
        m_data[m]      = s_data[g];
        m_v[m]         = '0;
        m_v[m][s_dest[g]] = 1'b1;
        m_gid[m]       = g;
        m_ptr[m]       = (g + 1) % NPU;
        m_lock_v[m]    = s_lock[g];
        m_lock_id[m]   = g;
      end else begin
        m_v[m]      = '0;
        m_lock_v[m] = 1'b0;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NPU; i++) begin
      rr_if.req_data[i*DW +: DW] = s_data[i];
      rr_if.req_idx[i*IL +: IL]  = {s_dest[i], s_valid[i]};
      rr_if.req_lock[i]          = s_lock[i];
      fx_if.req_data[i*DW +: DW] = s_data[i];
      fx_if.req_idx[i*IL +: IL]  = {s_dest[i], s_valid[i]};
      fx_if.req_lock[i]          = s_lock[i];
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NPU; i++) begin
      s_data[i] = '0; s_valid[i] = 1'b0; s_dest[i] = '0; s_lock[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_all();
    drive();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic prime_pu3();
    clear_all();
    s_valid[3] = 1'b1;
    drive();
    tick();
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b0;
    clear_all();
    drive();
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_out(m) !== 28'h0) begin
        errors++;
        $display("[TB] FAIL reset_out mode=%0d act=%h exp=%h", m, dut_out(m), 28'h0);
      end
      checks++;
      if (dut_ready(m) !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_ready mode=%0d act=%h exp=00", m, dut_ready(m));
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    clear_all();
    s_valid[3] = 1'b1; s_data[3] = 16'h1234; s_dest[3] = 3'd5;
    drive();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_ready(m) !== 8'h08) begin
        errors++;
        $display("[TB] FAIL single_ready mode=%0d act=%h exp=08", m, dut_ready(m));
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_out(m) !== {16'h1234, 8'h20, 3'd3, 1'b0}) begin
        errors++;
        $display("[TB] FAIL single_out mode=%0d act=%h exp=%h", m, dut_out(m),
                 {16'h1234, 8'h20, 3'd3, 1'b0});
      end
    end
    clear_all();
    drive();
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_out(m) !== {16'h1234, 8'h00, 3'd3, 1'b0}) begin
        errors++;
        $display("[TB] FAIL single_hold mode=%0d act=%h exp=%h", m, dut_out(m),
                 {16'h1234, 8'h00, 3'd3, 1'b0});
      end
    end
  endtask

  task automatic test_rr_fairness();
    int cnt [NPU];
    logic [NPU-1:0] exp;
    do_reset();
    for (int i = 0; i < NPU; i++) begin
      s_valid[i] = 1'b1; s_data[i] = 16'(i * 16'h111); s_dest[i] = LOG'(i); cnt[i] = 0;
    end
    drive();
    for (int c = 0; c <= NPU; c++) begin
      #1;
      exp = '0;
      exp[c % NPU] = 1'b1;
      checks++;
      if (rr_if.req_ready !== exp) begin
        errors++;
        $display("[TB] FAIL rr_order cycle=%0d act=%h exp=%h", c, rr_if.req_ready, exp);
      end
      checks++;
      if (fx_if.req_ready !== 8'h01) begin
        errors++;
        $display("[TB] FAIL fixed_all cycle=%0d act=%h exp=01", c, fx_if.req_ready);
      end
      if (c < NPU) begin
        for (int i = 0; i < NPU; i++) if (rr_if.req_ready[i]) cnt[i]++;
      end
      tick();
      checks++;
      if (dut_out(1) !== model_out(1)) begin
        errors++;
        $display("[TB] FAIL rr_out cycle=%0d act=%h exp=%h", c, dut_out(1), model_out(1));
      end
    end
    for (int i = 0; i < NPU; i++) begin
      checks++;
      if (cnt[i] != 1) begin
        errors++;
        $display("[TB] FAIL rr_share pu=%0d act=%0d exp=1", i, cnt[i]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    clear_all();
    s_valid[2] = 1'b1; s_dest[2] = 3'd7;
    s_valid[6] = 1'b1; s_dest[6] = 3'd0; s_data[6] = 16'h6666;
    for (int c = 0; c < 6; c++) begin
      s_data[2] = 16'($urandom);
      drive();
      #1;
      checks++;
      if (fx_if.req_ready !== 8'h04) begin
        errors++;
        $display("[TB] FAIL fixed_ready cycle=%0d act=%h exp=04", c, fx_if.req_ready);
      end
      checks++;
      if (rr_if.req_ready !== model_ready(1)) begin
        errors++;
        $display("[TB] FAIL fixed_rr_ready cycle=%0d act=%h exp=%h", c, rr_if.req_ready, model_ready(1));
      end
      tick();
      checks++;
      if (dut_out(0) !== {s_data[2], 8'h80, 3'd2, 1'b0}) begin
        errors++;
        $display("[TB] FAIL fixed_out cycle=%0d act=%h exp=%h", c, dut_out(0),
                 {s_data[2], 8'h80, 3'd2, 1'b0});
      end
    end
  endtask

  task automatic test_lock();
    logic [DW-1:0] wd;
    logic lk;
    do_reset();
    prime_pu3();
    clear_all();
    s_valid[1] = 1'b1; s_data[1] = 16'hAAAA; s_dest[1] = 3'd2;
    s_valid[4] = 1'b1; s_dest[4] = 3'd6;
    for (int w = 0; w < 3; w++) begin
      wd = 16'h4000 + 16'(w);
      lk = (w < 2);
      s_data[4] = wd; s_lock[4] = lk;
      drive();
      #1;
      checks++;
      if (rr_if.req_ready !== 8'h10) begin
        errors++;
        $display("[TB] FAIL lock_ready word=%0d act=%h exp=10", w, rr_if.req_ready);
      end
      tick();
      checks++;
      if (dut_out(1) !== {wd, 8'h40, 3'd4, lk}) begin
        errors++;
        $display("[TB] FAIL lock_out word=%0d act=%h exp=%h", w, dut_out(1), {wd, 8'h40, 3'd4, lk});
      end
      checks++;
      if (dut_out(0) !== model_out(0)) begin
        errors++;
        $display("[TB] FAIL lock_fixed word=%0d act=%h exp=%h", w, dut_out(0), model_out(0));
      end
    end
    s_valid[4] = 1'b0; s_lock[4] = 1'b0;
    drive();
    #1;
    checks++;
    if (rr_if.req_ready !== 8'h02) begin
      errors++;
      $display("[TB] FAIL lock_after_ready act=%h exp=02", rr_if.req_ready);
    end
    tick();
    checks++;
    if (dut_out(1) !== {16'hAAAA, 8'h04, 3'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL lock_after_out act=%h exp=%h", dut_out(1), {16'hAAAA, 8'h04, 3'd1, 1'b0});
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    prime_pu3();
    clear_all();
    s_valid[4] = 1'b1; s_lock[4] = 1'b1; s_data[4] = 16'h4444; s_dest[4] = 3'd1;
    s_valid[5] = 1'b1; s_data[5] = 16'h5555; s_dest[5] = 3'd2;
    drive();
    tick();
    checks++;
    if (dut_out(1) !== {16'h4444, 8'h02, 3'd4, 1'b1}) begin
      errors++;
      $display("[TB] FAIL drop_locked act=%h exp=%h", dut_out(1), {16'h4444, 8'h02, 3'd4, 1'b1});
    end
    s_valid[4] = 1'b0;
    drive();
    #1;
    checks++;
    if (rr_if.req_ready !== 8'h20) begin
      errors++;
      $display("[TB] FAIL drop_ready act=%h exp=20", rr_if.req_ready);
    end
    tick();
    checks++;
    if (dut_out(1) !== {16'h5555, 8'h04, 3'd5, 1'b0}) begin
      errors++;
      $display("[TB] FAIL drop_out act=%h exp=%h", dut_out(1), {16'h5555, 8'h04, 3'd5, 1'b0});
    end
    clear_all();
    s_valid[4] = 1'b1; s_lock[4] = 1'b1; s_data[4] = 16'h4444; s_dest[4] = 3'd1;
    drive();
    tick();
    clear_all();
    drive();
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_out(m) !== {16'h4444, 8'h00, 3'd4, 1'b0}) begin
        errors++;
        $display("[TB] FAIL drop_idle mode=%0d act=%h exp=%h", m, dut_out(m),
                 {16'h4444, 8'h00, 3'd4, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    prime_pu3();
    clear_all();
    s_valid[4] = 1'b1; s_lock[4] = 1'b1; s_data[4] = 16'h4321; s_dest[4] = 3'd3;
    drive();
    tick();
    checks++;
    if (dut_out(1) !== {16'h4321, 8'h08, 3'd4, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mid_locked act=%h exp=%h", dut_out(1), {16'h4321, 8'h08, 3'd4, 1'b1});
    end
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_out(m) !== 28'h0) begin
        errors++;
        $display("[TB] FAIL mid_reset_out mode=%0d act=%h exp=0", m, dut_out(m));
      end
    end
    for (int i = 0; i < NPU; i++) begin
      s_valid[i] = 1'b1; s_data[i] = 16'hB000 + 16'(i); s_dest[i] = LOG'(NPU - 1 - i);
    end
    drive();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (rr_if.req_ready !== 8'h01) begin
      errors++;
      $display("[TB] FAIL mid_first_rr act=%h exp=01", rr_if.req_ready);
    end
    tick();
    checks++;
    if (dut_out(1) !== {16'hB000, 8'h80, 3'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_first_out act=%h exp=%h", dut_out(1), {16'hB000, 8'h80, 3'd0, 1'b0});
    end
  endtask

  task automatic test_random();
    int wait_cnt [NPU];
    int max_wait;
    logic locks_on;
    do_reset();
    max_wait = 0;
    for (int i = 0; i < NPU; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 600; c++) begin
      locks_on = (c >= 300);
      for (int i = 0; i < NPU; i++) begin
        if (!s_valid[i] || last_g[1] == i) begin
          s_valid[i] = ($urandom_range(0, 9) < 6);
          s_data[i]  = 16'($urandom);
          s_dest[i]  = LOG'($urandom_range(0, NPU - 1));
          s_lock[i]  = locks_on && ($urandom_range(0, 9) < 3);
        end
      end
      drive();
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_ready(m) !== model_ready(m)) begin
          errors++;
          $display("[TB] FAIL rand_ready cycle=%0d mode=%0d act=%h exp=%h", c, m, dut_ready(m), model_ready(m));
        end
      end
      for (int i = 0; i < NPU; i++) begin
        if (s_valid[i] && !rr_if.req_ready[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (!locks_on && wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_out(m) !== model_out(m)) begin
          errors++;
          $display("[TB] FAIL rand_out cycle=%0d mode=%0d act=%h exp=%h", c, m, dut_out(m), model_out(m));
        end
      end
    end
    checks++;
    if (max_wait > NPU - 1) begin
      errors++;
      $display("[TB] FAIL rr_starvation act=%0d exp<=%0d", max_wait, NPU - 1);
    end
  endtask

  initial begin
    clear_all();
    model_reset();
    test_reset();
    test_single();
    test_rr_fairness();
    test_fixed_priority();
    test_lock();
    test_lock_drop();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
